// File: rtl/servo_array_ctrl.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel width registers
// updated once per frame (jog, track-to-target, or freeze) and clamped to [PW_MIN,PW_MAX].
module servo_array_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int CLK_PER_FRAME = 20000,
  parameter int CW            = 15,
  parameter int PWW           = 12,
  parameter int PW_MIN        = 1000,
  parameter int PW_MAX        = 2200,
  parameter int PW_INIT       = 1000,
  parameter int STEP          = 10
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     toggle,
  input  logic [NUM_CH-1:0]     freeze,
  input  logic [NUM_CH-1:0]     track,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [3:0]            ld_ch,
  input  logic [PWW-1:0]        ld_pw,
  output logic [NUM_CH-1:0]     pwm,
  output logic [NUM_CH*PWW-1:0] pw_bus,
  output logic [NUM_CH-1:0]     at_min,
  output logic [NUM_CH-1:0]     at_max,
  output logic                  frame_stb
);

  localparam int PWE = PWW + 1;
  localparam int MW  = (CW > PWW) ? CW : PWW;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_PER_FRAME - 1);
  localparam logic [CW-1:0]  CNT_PRE  = CW'(CLK_PER_FRAME - 2);
  localparam logic [PWE-1:0] MIN_E    = PWE'(PW_MIN);
  localparam logic [PWE-1:0] MAX_E    = PWE'(PW_MAX);
  localparam logic [PWE-1:0] STEP_E   = PWE'(STEP);
  localparam logic [PWW-1:0] MIN_W    = PWW'(PW_MIN);
  localparam logic [PWW-1:0] MAX_W    = PWW'(PW_MAX);
  localparam logic [PWW-1:0] INIT_W   = PWW'(PW_INIT);

  function automatic logic [PWW-1:0] clamp_pw(input logic [PWW-1:0] v);
    logic [PWE-1:0] ve;
    ve = {1'b0, v};
    if (ve < MIN_E) begin
      return MIN_W;
    end else if (ve > MAX_E) begin
      return MAX_W;
    end else begin
      return v;
    end
  endfunction

  // One extra bit of headroom keeps pw+STEP and the distance terms from wrapping.
  function automatic logic [PWW-1:0] next_pw(input logic [PWW-1:0] pw, input logic [PWW-1:0] tgt,
                                             input logic frz, input logic trk, input logic tog);
    logic [PWE-1:0] p;
    logic [PWE-1:0] t;
    logic [PWE-1:0] r;
    p = {1'b0, pw};
    t = {1'b0, tgt};
    if (frz) begin
      r = p;
    end else if (trk) begin
      if (t > p) begin
        r = ((t - p) > STEP_E) ? (p + STEP_E) : t;
      end else if (t < p) begin
        r = ((p - t) > STEP_E) ? (p - STEP_E) : t;
      end else begin
        r = p;
      end
    end else if (tog) begin
      r = ((p + STEP_E) > MAX_E) ? MAX_E : (p + STEP_E);
    end else begin
      r = (p < (MIN_E + STEP_E)) ? MIN_E : (p - STEP_E);
    end
    return r[PWW-1:0];
  endfunction

  logic [CW-1:0]     cnt_r;
  logic              upd_s;
  logic              ld_fire_s;
  logic              ld_ready_r;
  logic              frame_stb_r;
  logic [PWW-1:0]    pw_r     [NUM_CH];
  logic [PWW-1:0]    tgt_r    [NUM_CH];
  logic [PWW-1:0]    pw_nxt_s [NUM_CH];
  logic [NUM_CH-1:0] pwm_r;
  logic [NUM_CH-1:0] at_min_r;
  logic [NUM_CH-1:0] at_max_r;

  // Widths only move on the update cycle so each frame is generated from one stable value.
  always_comb begin
    upd_s     = (cnt_r == CNT_LAST);
    ld_fire_s = ld_valid & ld_ready_r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (upd_s) begin
        pw_nxt_s[i] = next_pw(pw_r[i], tgt_r[i], freeze[i], track[i], toggle[i]);
      end else begin
        pw_nxt_s[i] = pw_r[i];
      end
    end
  end

  // Frame counter; strobe and ready are registered one cycle ahead so they line up with U.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_r       <= '0;
      frame_stb_r <= 1'b0;
      ld_ready_r  <= 1'b0;
    end else begin
      cnt_r       <= upd_s ? '0 : (cnt_r + 1'b1);
      frame_stb_r <= (cnt_r == CNT_PRE);
      ld_ready_r  <= (cnt_r != CNT_PRE);
    end
  end

  // Per-channel width, target and PWM registers; loads to absent channels match nothing.
  always_ff @(posedge mclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        pw_r[i]     <= INIT_W;
        tgt_r[i]    <= INIT_W;
        pwm_r[i]    <= 1'b0;
        at_min_r[i] <= (PW_INIT == PW_MIN);
        at_max_r[i] <= (PW_INIT == PW_MAX);
      end else begin
        pw_r[i]     <= pw_nxt_s[i];
        pwm_r[i]    <= (MW'(cnt_r) < MW'(pw_r[i]));
        at_min_r[i] <= (pw_nxt_s[i] == MIN_W);
        at_max_r[i] <= (pw_nxt_s[i] == MAX_W);
        if (ld_fire_s && (ld_ch == 4'(i))) begin
          tgt_r[i] <= clamp_pw(ld_pw);
        end else begin
          tgt_r[i] <= tgt_r[i];
        end
      end
    end
  end

  always_comb begin
    pw_bus = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pw_bus[i*PWW +: PWW] = pw_r[i];
    end
  end

  assign pwm       = pwm_r;
  assign at_min    = at_min_r;
  assign at_max    = at_max_r;
  assign frame_stb = frame_stb_r;
  assign ld_ready  = ld_ready_r;

endmodule
